// File: rtl/coin_pkg.sv
// Shared encodings and geometry helpers for the falling-coin scheduler.
// Sprite size doubles per scale step; x is always lane centre minus half the sprite width.
package coin_pkg;

    typedef enum logic [1:0] {
        SCALE_X1 = 2'd0,
        SCALE_X2 = 2'd1,
        SCALE_X4 = 2'd2
    } scale_e;

    typedef enum logic [1:0] {
        LANE_LEFT   = 2'd0,
        LANE_CENTRE = 2'd1,
        LANE_RIGHT  = 2'd2
    } lane_e;

    localparam int SCREEN_W    = 1280;
    localparam int SCREEN_H    = 720;
    localparam int SPRITE_BASE = 32;

    function automatic logic [15:0] half_width(input scale_e s);
        case (s)
            SCALE_X2: half_width = 16'(SPRITE_BASE);
            SCALE_X4: half_width = 16'(SPRITE_BASE * 2);
            default:  half_width = 16'(SPRITE_BASE / 2);
        endcase
    endfunction

    function automatic scale_e scale_from_y(input logic [15:0] y,
                                            input logic [15:0] y_x2,
                                            input logic [15:0] y_x4);
        if (y < y_x2) return SCALE_X1;
        if (y < y_x4) return SCALE_X2;
        return SCALE_X4;
    endfunction

    function automatic logic [15:0] slot_x(input lane_e lane, input scale_e s,
                                           input logic [15:0] x_l,
                                           input logic [15:0] x_c,
                                           input logic [15:0] x_r);
        logic [15:0] centre;
        case (lane)
            LANE_LEFT:  centre = x_l;
            LANE_RIGHT: centre = x_r;
            default:    centre = x_c;
        endcase
        return centre - half_width(s);
    endfunction

    // Only three lanes exist, so the fourth random code folds onto the centre lane.
    function automatic lane_e lane_from_rand(input logic [1:0] r);
        return (r == 2'd3) ? LANE_CENTRE : lane_e'(r);
    endfunction

endpackage

// File: rtl/coin_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) used to pick spawn lanes; steps once per enable.
module coin_lfsr8 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    output logic [7:0] o_state
);

    logic [7:0] r_state;
    logic       w_fb;

    assign w_fb = r_state[7] ^ r_state[5] ^ r_state[4] ^ r_state[3];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= 8'hA5;
        end else if (i_en) begin
            r_state <= {r_state[6:0], w_fb};
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/coin_spawn_scheduler.sv
// Per-frame coin scheduler: on each v_sync rising edge it walks every slot (fall, collect, miss),
// then spends one cycle spawning a coin into the lowest free slot when the spawn interval allows.
module coin_spawn_scheduler
    import coin_pkg::*;
#(
    parameter int NUM_SLOTS    = 4,
    parameter int SPAWN_FRAMES = 90,
    parameter int Y_END        = SCREEN_H - 4 * SPRITE_BASE,
    parameter int Y_SCALE2     = 300,
    parameter int Y_SCALE4     = 450,
    parameter int LANE_L       = 400,
    parameter int LANE_C       = SCREEN_W / 2,
    parameter int LANE_R       = 880
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_v_sync,
    input  logic [NUM_SLOTS-1:0]      i_collect,
    output logic [NUM_SLOTS-1:0]      o_slot_active,
    output logic [16*NUM_SLOTS-1:0]   o_slot_x,
    output logic [16*NUM_SLOTS-1:0]   o_slot_y,
    output logic [2*NUM_SLOTS-1:0]    o_slot_scale,
    output logic                      o_collect_pulse,
    output logic                      o_miss_pulse,
    output logic [15:0]               o_score,
    output logic                      o_busy
);

    localparam int KW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CW = $clog2(SPAWN_FRAMES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(SPAWN_FRAMES);
    localparam logic [15:0]   YE = 16'(Y_END);
    localparam logic [15:0]   Y2 = 16'(Y_SCALE2);
    localparam logic [15:0]   Y4 = 16'(Y_SCALE4);
    localparam logic [15:0]   XL = 16'(LANE_L);
    localparam logic [15:0]   XC = 16'(LANE_C);
    localparam logic [15:0]   XR = 16'(LANE_R);

    typedef enum logic [1:0] {S_WAIT, S_STEP, S_SPAWN} state_e;

    state_e              r_state;
    logic [KW-1:0]       r_k;
    logic                r_vs_q;
    logic [NUM_SLOTS-1:0] r_flag;
    logic [NUM_SLOTS-1:0] r_active;
    logic [15:0]         r_y [NUM_SLOTS];
    logic [15:0]         r_x [NUM_SLOTS];
    scale_e              r_scale [NUM_SLOTS];
    lane_e               r_lane [NUM_SLOTS];
    logic [CW-1:0]       r_cnt;
    logic                r_collect_p;
    logic                r_miss_p;
    logic [15:0]         r_score;
    logic                r_busy;

    logic                w_tick;
    logic                w_lfsr_en;
    logic [7:0]          w_lfsr;
    logic                w_unused_lfsr;
    logic [15:0]         w_y_next;
    scale_e              w_scale_next;
    logic [CW-1:0]       w_cnt_inc;
    logic                w_free_any;
    logic [KW-1:0]       w_free_idx;
    lane_e               w_spawn_lane;
    logic [NUM_SLOTS-1:0] w_flag_clr;

    coin_lfsr8 u_lfsr (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (w_lfsr_en),
        .o_state (w_lfsr)
    );

    assign w_lfsr_en     = (r_state == S_SPAWN);
    assign w_unused_lfsr = ^w_lfsr[7:2];
    assign w_spawn_lane  = lane_from_rand(w_lfsr[1:0]);
    assign w_tick        = i_v_sync & ~r_vs_q;
    assign w_y_next      = r_y[r_k] + 16'd1;
    assign w_scale_next  = scale_from_y(w_y_next, Y2, Y4);
    assign w_cnt_inc     = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);
    assign w_flag_clr    = (r_state == S_STEP) ? (NUM_SLOTS'(1) << r_k) : '0;

    always_comb begin
        w_free_any = 1'b0;
        w_free_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!r_active[i]) begin
                w_free_any = 1'b1;
                w_free_idx = KW'(i);
            end
        end
    end

    // A request landing in the very cycle its slot is consumed survives into the next frame.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_flag <= '0;
        end else begin
            r_flag <= (r_flag & ~w_flag_clr) | i_collect;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_WAIT;
            r_k         <= '0;
            r_vs_q      <= 1'b0;
            r_active    <= '0;
            r_cnt       <= '0;
            r_collect_p <= 1'b0;
            r_miss_p    <= 1'b0;
            r_score     <= '0;
            r_busy      <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_y[i]     <= '0;
                r_x[i]     <= '0;
                r_scale[i] <= SCALE_X1;
                r_lane[i]  <= LANE_LEFT;
            end
        end else begin
            r_vs_q      <= i_v_sync;
            r_collect_p <= 1'b0;
            r_miss_p    <= 1'b0;
            case (r_state)
                S_WAIT: begin
                    if (w_tick) begin
                        r_state <= S_STEP;
                        r_k     <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_STEP: begin
                    if (r_active[r_k]) begin
                        if (r_flag[r_k]) begin
                            r_active[r_k] <= 1'b0;
                            r_collect_p   <= 1'b1;
                            r_score       <= r_score + 16'd1;
                        end else if (w_y_next >= YE) begin
                            r_active[r_k] <= 1'b0;
                            r_miss_p      <= 1'b1;
                        end else begin
                            r_y[r_k]     <= w_y_next;
                            r_scale[r_k] <= w_scale_next;
                            r_x[r_k]     <= slot_x(r_lane[r_k], w_scale_next, XL, XC, XR);
                        end
                    end
                    if (r_k == KW'(NUM_SLOTS - 1)) begin
                        r_state <= S_SPAWN;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                S_SPAWN: begin
                    r_state <= S_WAIT;
                    r_busy  <= 1'b0;
                    if ((w_cnt_inc == CNT_MAX) && w_free_any) begin
                        r_cnt                <= '0;
                        r_active[w_free_idx] <= 1'b1;
                        r_y[w_free_idx]      <= '0;
                        r_scale[w_free_idx]  <= SCALE_X1;
                        r_lane[w_free_idx]   <= w_spawn_lane;
                        r_x[w_free_idx]      <= slot_x(w_spawn_lane, SCALE_X1, XL, XC, XR);
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state <= S_WAIT;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        o_slot_x     = '0;
        o_slot_y     = '0;
        o_slot_scale = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            o_slot_x[16*i +: 16]   = r_x[i];
            o_slot_y[16*i +: 16]   = r_y[i];
            o_slot_scale[2*i +: 2] = r_scale[i];
        end
    end

    assign o_slot_active   = r_active;
    assign o_collect_pulse = r_collect_p;
    assign o_miss_pulse    = r_miss_p;
    assign o_score         = r_score;
    assign o_busy          = r_busy;

endmodule
